// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the bit-serial ALU sequencer:
//   op_e    : opcode encodings presented on op_i
//   state_e : sequencer FSM state encoding
//   init_carry : carry-in applied to bit 0 for a given opcode
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_DEC = 2'b10,
    OP_INC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // SUB is A + ~B + 1 and INC is A + 0 + 1; the others start with no carry.
  function automatic logic init_carry(input op_e op);
    logic c0;
    case (op)
      OP_SUB:  c0 = 1'b1;
      OP_INC:  c0 = 1'b1;
      OP_ADD:  c0 = 1'b0;
      OP_DEC:  c0 = 1'b0;
      default: c0 = 1'b0;
    endcase
    return c0;
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// -----------------------------------------------------------------------------
// alu_flag_gen
// Combinational flag derivation for a completed serial result.
// Ports:
//   sum      in  WIDTH  completed result
//   carry    in  1      carry out of the MSB
//   c_msb_in in  1      carry into the MSB
//   zero     out 1      sum == 0
//   neg      out 1      sum MSB
//   ovf      out 1      signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------
module alu_flag_gen #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] sum,
  input  logic             carry,
  input  logic             c_msb_in,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  assign zero = (sum == {WIDTH{1'b0}});
  assign neg  = sum[WIDTH-1];
  assign ovf  = c_msb_in ^ carry;

endmodule

// File: rtl/alu_serial_sequencer.sv
// -----------------------------------------------------------------------------
// alu_serial_sequencer
// Bit-serial controller for an external 1-bit adder slice. Latches operands
// and opcode on start, feeds one bit pair plus carry per clock (LSB first),
// collects sum bits and produces result and flags.
// Ports:
//   clk, rst_n       clock (rising edge), synchronous active-low reset
//   start_i          request, sampled only in IDLE
//   op_i             00 ADD, 01 SUB, 10 DEC, 11 INC
//   a_i, b_i         operands, latched with start
//   slice_a_o/b_o/ci_o  bit pair and carry-in to the slice (0 outside RUN)
//   slice_o_i/co_i   sum bit and carry-out from the slice
//   busy_o           high in RUN
//   done_o           one-cycle pulse when result and flags update
//   result_o, carry_o, zero_o, neg_o, ovf_o  last completed result and flags
// -----------------------------------------------------------------------------
module alu_serial_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             slice_a_o,
  output logic             slice_b_o,
  output logic             slice_ci_o,
  input  logic             slice_o_i,
  input  logic             slice_co_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             neg_o,
  output logic             ovf_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_r;
  state_e           state_next_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_next_s;
  logic [WIDTH-1:0] b_cond_s;
  logic [WIDTH-1:0] result_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic             carry_r;
  logic             busy_r;
  logic             done_r;
  logic             carry_out_r;
  logic             zero_r;
  logic             neg_r;
  logic             ovf_r;
  logic             run_s;
  logic             last_bit_s;
  logic             zero_s;
  logic             neg_s;
  logic             ovf_s;

  assign run_s      = (state_r == RUN);
  assign last_bit_s = (bit_cnt_r == LAST_BIT);

  // Slice drive is forced low outside RUN so the slice sees a quiet bus.
  assign slice_a_o  = run_s & a_r[bit_cnt_r];
  assign slice_b_o  = run_s & b_r[bit_cnt_r];
  assign slice_ci_o = run_s & carry_r;

  assign busy_o   = busy_r;
  assign done_o   = done_r;
  assign result_o = result_r;
  assign carry_o  = carry_out_r;
  assign zero_o   = zero_r;
  assign neg_o    = neg_r;
  assign ovf_o    = ovf_r;

  // Condition operand B according to the opcode.
  always_comb begin
    b_cond_s = b_i;
    case (op_e'(op_i))
      OP_ADD:  b_cond_s = b_i;
      OP_SUB:  b_cond_s = ~b_i;
      OP_DEC:  b_cond_s = {WIDTH{1'b1}};
      OP_INC:  b_cond_s = {WIDTH{1'b0}};
      default: b_cond_s = b_i;
    endcase
  end

  // Sum vector including the bit currently returned by the slice.
  always_comb begin
    sum_next_s            = sum_r;
    sum_next_s[bit_cnt_r] = slice_o_i;
  end

  // On the last bit the carry register still holds the carry into the MSB,
  // so it feeds the overflow term directly.
  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .sum      (sum_next_s),
    .carry    (slice_co_i),
    .c_msb_in (carry_r),
    .zero     (zero_s),
    .neg      (neg_s),
    .ovf      (ovf_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_bit_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Operand latch, serial sum/carry collection and registered result/flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      bit_cnt_r   <= {CNT_W{1'b0}};
      carry_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      carry_out_r <= 1'b0;
      zero_r      <= 1'b0;
      neg_r       <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_i) begin
            a_r       <= a_i;
            b_r       <= b_cond_s;
            sum_r     <= {WIDTH{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            carry_r   <= init_carry(op_e'(op_i));
            busy_r    <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        RUN: begin
          sum_r   <= sum_next_s;
          carry_r <= slice_co_i;
          if (last_bit_s) begin
            result_r    <= sum_next_s;
            carry_out_r <= slice_co_i;
            zero_r      <= zero_s;
            neg_r       <= neg_s;
            ovf_r       <= ovf_s;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
          end else begin
            bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
